// File: rtl/product_accumulator_if.sv
// Product/result bundle between the serial multiplier, the accumulator and its consumer.
interface product_accumulator_if #(
    parameter int unsigned N_TERMS = 4,
    parameter int unsigned ACC_W   = 18
);
    localparam int unsigned CNT_W = $clog2(N_TERMS) + 1;

    logic [15:0]      Product;
    logic             Product_Valid;
    logic             clear;
    logic [ACC_W-1:0] Sum;
    logic             Sum_Valid;
    logic             Sum_Ready;
    logic             Overflow;
    logic [CNT_W-1:0] Term_Count;
    logic             Drop;

    // Producer/consumer side (testbench or surrounding logic)
    modport master (
        output Product, Product_Valid, clear, Sum_Ready,
        input  Sum, Sum_Valid, Overflow, Term_Count, Drop
    );

    // Accumulator side
    modport slave (
        input  Product, Product_Valid, clear, Sum_Ready,
        output Sum, Sum_Valid, Overflow, Term_Count, Drop
    );
endinterface

// File: rtl/product_accumulator.sv
// Sums groups of N_TERMS products into a result held in a one-deep output slot.
// Accumulation never stalls: a group completing while the slot is still unaccepted is dropped.
module product_accumulator #(
    parameter int unsigned N_TERMS = 4,
    parameter int unsigned ACC_W   = 18
) (
    input logic                  clk,
    input logic                  rst,
    product_accumulator_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(N_TERMS) + 1;
    localparam int unsigned EXT_W = ACC_W - 16;

    logic [ACC_W-1:0] acc, acc_next;
    logic [CNT_W-1:0] term_count, term_count_next;
    logic             ovf, ovf_next;
    logic [ACC_W-1:0] sum, sum_next;
    logic             sum_ovf, sum_ovf_next;
    logic             sum_valid, sum_valid_next;
    logic             drop, drop_next;

    logic [ACC_W-1:0] product_ext;
    logic [ACC_W:0]   add_full;
    logic             last_term;
    logic             slot_free;

    // Adder with carry out of the accumulator width
    always_comb begin
        product_ext = {{EXT_W{1'b0}}, bus.Product};
        add_full    = {1'b0, acc} + {1'b0, product_ext};
        last_term   = bus.Product_Valid && !bus.clear &&
                      (term_count == CNT_W'(N_TERMS - 1));
        slot_free   = !sum_valid || bus.Sum_Ready;
    end

    // Next-state for the accumulator and the output slot
    always_comb begin
        acc_next        = acc;
        term_count_next = term_count;
        ovf_next        = ovf;
        sum_next        = sum;
        sum_ovf_next    = sum_ovf;
        sum_valid_next  = sum_valid;
        drop_next       = 1'b0;

        // Acceptance empties the slot; a same-edge load below refills it
        if (sum_valid && bus.Sum_Ready) begin
            sum_valid_next = 1'b0;
        end

        if (bus.clear) begin
            // Restart; a product on the same edge becomes the first term
            acc_next        = bus.Product_Valid ? product_ext : '0;
            term_count_next = bus.Product_Valid ? CNT_W'(1) : '0;
            ovf_next        = 1'b0;
        end else if (last_term) begin
            acc_next        = '0;
            term_count_next = '0;
            ovf_next        = 1'b0;
            if (slot_free) begin
                sum_next       = add_full[ACC_W-1:0];
                sum_ovf_next   = ovf | add_full[ACC_W];
                sum_valid_next = 1'b1;
            end else begin
                drop_next = 1'b1;
            end
        end else if (bus.Product_Valid) begin
            acc_next        = add_full[ACC_W-1:0];
            term_count_next = term_count + CNT_W'(1);
            ovf_next        = ovf | add_full[ACC_W];
        end
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc        <= '0;
            term_count <= '0;
            ovf        <= 1'b0;
            sum        <= '0;
            sum_ovf    <= 1'b0;
            sum_valid  <= 1'b0;
            drop       <= 1'b0;
        end else begin
            acc        <= acc_next;
            term_count <= term_count_next;
            ovf        <= ovf_next;
            sum        <= sum_next;
            sum_ovf    <= sum_ovf_next;
            sum_valid  <= sum_valid_next;
            drop       <= drop_next;
        end
    end

    assign bus.Sum        = sum;
    assign bus.Overflow   = sum_ovf;
    assign bus.Sum_Valid  = sum_valid;
    assign bus.Term_Count = term_count;
    assign bus.Drop       = drop;
endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
- Downstream stage of the 8x8 unsigned serial multiplier. It consumes each 16-bit product, qualified by the multiplier's one-cycle valid pulse.
- Sums groups of N_TERMS consecutive products into a dot-product result.
- Presents each group sum on a valid/ready output port. A double-buffered accumulator lets the next group keep collecting while the previous sum waits for acceptance.

Parameters:
N_TERMS, 4, products per group (>=2)
ACC_W, 18, accumulator/result width in bits (>=16); sums wrap modulo 2^ACC_W

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
Product  input  16  unsigned product from the multiplier
Product_Valid  input  1  one-cycle pulse, Product valid this cycle
clear  input  1  synchronous group restart
Sum  output  ACC_W  completed group sum
Sum_Valid  output  1  Sum holds an unaccepted result
Sum_Ready  input  1  consumer accepts Sum when high with Sum_Valid
Overflow  output  1  a carry out of ACC_W occurred in the group now on Sum
Term_Count  output  log2ceil(N_TERMS)+1  products in the group in progress
Drop  output  1  one-cycle pulse, a completed group was discarded

Behaviour:
- Reset (rst low, asynchronous): acc, Term_Count, Sum, Overflow, internal ovf flag, Sum_Valid and Drop are all 0.
- Accumulate: on a clk edge with Product_Valid=1 and clear=0, acc <= acc + zero-extend(Product) and Term_Count++. The internal ovf flag ORs in the carry out of bit ACC_W-1.
- Group complete: the edge where Product_Valid=1 and Term_Count==N_TERMS-1.
  - Result = acc + Product, with overflow = ovf | carry.
  - acc, Term_Count and ovf go to 0 on that edge.
  - Output slot free (Sum_Valid=0, or Sum_Ready=1 this cycle): Sum <= result, Overflow <= overflow, Sum_Valid <= 1. One-cycle latency from the last Product_Valid.
  - Output slot busy (Sum_Valid=1 and Sum_Ready=0): result discarded, Drop=1 for one cycle. Sum, Overflow and Sum_Valid unchanged.
- Output handshake:
  - Sum_Valid stays high, and Sum/Overflow stay stable, until an edge with Sum_Ready=1.
  - On that edge Sum_Valid <= 0, unless a group completes on the same edge; then the new result loads and Sum_Valid stays 1.
  - Sum_Ready while Sum_Valid=0 is ignored.
- clear=1:
  - acc, Term_Count and ovf restart.
  - If Product_Valid=1 on the same edge, that product becomes the first term: acc <= Product, Term_Count <= 1.
  - clear never affects Sum, Sum_Valid or Overflow.
  - With N_TERMS>=2, clear+Product_Valid never completes a group.
- Accumulation runs independently of the output slot state; no backpressure is sent upstream. The multiplier issues at most one product per 64 cycles, so back-to-back Product_Valid need not be expected. It must still be handled correctly, one term per cycle.
- Drop is 0 on every edge without a discarded group.
- Reset mid-group or with Sum pending: everything is lost, all outputs return to 0.

Test Plan:
- Reset, then products 100, 200, 300, 400 (pulses 64 cycles apart), Sum_Ready=1 -> Sum=1000 and Sum_Valid=1 on the edge after the 400 pulse. Overflow=0, Term_Count 1,2,3,0, Sum_Valid back to 0 next cycle.
- Four products of 65025 (255*255), ACC_W=18 -> Sum=260100, Overflow=0. Rerun with ACC_W=16 -> Sum=260100 mod 65536=63492, Overflow=1.
- Group 1 completes with Sum_Ready=0 held; group 2 of 1,2,3,4 completes -> Drop pulses once, Sum stays group-1 value. Then raise Sum_Ready -> Sum_Valid falls next edge.
- Sum_Ready asserted on exactly the edge group 2 completes (sum 10) -> no Drop, Sum switches to 10, Sum_Valid stays 1 continuously.
- After products 5 and 7, assert clear together with Product_Valid (product 9), then products 1, 1, 1 -> Sum=12 (9+1+1+1), Term_Count=1 after the clear edge.
- Pull rst low mid-group, with Term_Count=2 and Sum_Valid=1 -> all outputs 0 immediately without a clock edge. Next group of 1,1,1,1 -> Sum=4.
